// File: rtl/alu_pkg.sv
// alu_pkg: opcode and shift-mode constants shared by the ALU
// and by any decoder that generates alu_ctrl.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b1001;

  // Shift modes equal the low two bits of the shift opcodes.
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter (SLL/SRL/SRA).
// Ports: data_in, amt (log2 WIDTH bits), mode -> data_out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (mode)
      SH_SLL:  data_out = data_in << amt;
      SH_SRL:  data_out = data_in >> amt;
      SH_SRA:  data_out = $signed(data_in) >>> amt;
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU, one-cycle latency.
// Ports: clk, rst (sync high), in1, in2, alu_ctrl -> alu_result, zero_flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [OP_W-1:0]  alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh_out;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .data_in  (in1),
    .amt      (in2[SHW-1:0]),
    .mode     (alu_ctrl[1:0]),
    .data_out (sh_out)
  );

  always_comb begin
    result_d = '0;
    case (alu_ctrl)
      OP_AND:  result_d = in1 & in2;
      OP_OR:   result_d = in1 | in2;
      OP_ADD:  result_d = in1 + in2;
      OP_SUB:  result_d = in1 - in2;
      OP_XOR:  result_d = in1 ^ in2;
      OP_SLL,
      OP_SRL,
      OP_SRA:  result_d = sh_out;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}},
                           $signed(in1) < $signed(in2)};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, in1 < in2};
      default: result_d = '0;
    endcase
    // Derived from the next result so flag and result never disagree.
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign alu_result = result_q;
  assign zero_flag  = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu (WIDTH=8).
// Each scenario task drives vectors and compares inline.
module tb_alu;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_result;
  logic       zero_flag;

  int tests;
  int fails;

  alu #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in1        (in1),
    .in2        (in2),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .zero_flag  (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic r);
    @(negedge clk);
    in1 = a;
    in2 = b;
    alu_ctrl = op;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(8'h03, 8'h04, OP_ADD, 1'b1);
    tests++;
    if ({zero_flag, alu_result} !== {1'b1, 8'h00}) begin
      fails++;
      $display("FAIL reset_c1: got %h/%b want 00/1", alu_result, zero_flag);
    end
    drive(8'hA5, 8'h5A, OP_OR, 1'b1);
    tests++;
    if ({zero_flag, alu_result} !== {1'b1, 8'h00}) begin
      fails++;
      $display("FAIL reset_c2: got %h/%b want 00/1", alu_result, zero_flag);
    end
    drive(8'h03, 8'h04, OP_ADD, 1'b0);
    tests++;
    if ({zero_flag, alu_result} !== {1'b0, 8'h07}) begin
      fails++;
      $display("FAIL reset_release: got %h/%b want 07/0", alu_result, zero_flag);
    end
  endtask

  task automatic test_logic_arith;
    logic [3:0] ops [5] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR};
    logic [7:0] exp [5] = '{8'h04, 8'h07, 8'h0B, 8'hFF, 8'h03};
    for (int i = 0; i < 5; i++) begin
      drive(8'h05, 8'h06, ops[i], 1'b0);
      tests++;
      if ({zero_flag, alu_result} !== {1'b0, exp[i]}) begin
        fails++;
        $display("FAIL logic_arith op=%b: got %h/%b want %h/0",
                 ops[i], alu_result, zero_flag, exp[i]);
      end
    end
  endtask

  task automatic test_shift;
    logic [7:0] a   [5] = '{8'h05, 8'h05, 8'h05, 8'h80, 8'h80};
    logic [7:0] b   [5] = '{8'h06, 8'h06, 8'h06, 8'h03, 8'h03};
    logic [3:0] ops [5] = '{OP_SLL, OP_SRL, OP_SRA, OP_SRA, OP_SRL};
    logic [7:0] exp [5] = '{8'h40, 8'h00, 8'h00, 8'hF0, 8'h10};
    logic       ez  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(a[i], b[i], ops[i], 1'b0);
      tests++;
      if ({zero_flag, alu_result} !== {ez[i], exp[i]}) begin
        fails++;
        $display("FAIL shift %0d: got %h/%b want %h/%b",
                 i, alu_result, zero_flag, exp[i], ez[i]);
      end
    end
  endtask

  task automatic test_compare;
    logic [7:0] a   [4] = '{8'h05, 8'h05, 8'hFF, 8'hFF};
    logic [7:0] b   [4] = '{8'h06, 8'h06, 8'h01, 8'h01};
    logic [3:0] ops [4] = '{OP_SLT, OP_SLTU, OP_SLT, OP_SLTU};
    logic [7:0] exp [4] = '{8'h01, 8'h01, 8'h01, 8'h00};
    logic       ez  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(a[i], b[i], ops[i], 1'b0);
      tests++;
      if ({zero_flag, alu_result} !== {ez[i], exp[i]}) begin
        fails++;
        $display("FAIL compare %0d: got %h/%b want %h/%b",
                 i, alu_result, zero_flag, exp[i], ez[i]);
      end
    end
  endtask

  task automatic test_wrap_reserved;
    logic [7:0] a   [4] = '{8'hFF, 8'h00, 8'h12, 8'h34};
    logic [7:0] b   [4] = '{8'h01, 8'h01, 8'h34, 8'h56};
    logic [3:0] ops [4] = '{OP_ADD, OP_SUB, 4'b1100, 4'b1111};
    logic [7:0] exp [4] = '{8'h00, 8'hFF, 8'h00, 8'h00};
    logic       ez  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(a[i], b[i], ops[i], 1'b0);
      tests++;
      if ({zero_flag, alu_result} !== {ez[i], exp[i]}) begin
        fails++;
        $display("FAIL wrap_reserved %0d: got %h/%b want %h/%b",
                 i, alu_result, zero_flag, exp[i], ez[i]);
      end
    end
  endtask

  task automatic test_hold;
    drive(8'h0F, 8'h30, OP_OR, 1'b0);
    in1 = 8'h00;
    in2 = 8'h00;
    alu_ctrl = OP_AND;
    #3;
    tests++;
    if ({zero_flag, alu_result} !== {1'b0, 8'h3F}) begin
      fails++;
      $display("FAIL hold: got %h/%b want 3F/0", alu_result, zero_flag);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a   [9] = '{8'h0F, 8'h0F, 8'h7F, 8'h10, 8'hAA,
                            8'h01, 8'h80, 8'h80, 8'h80};
    logic [7:0] b   [9] = '{8'h3C, 8'h3C, 8'h01, 8'h20, 8'h55,
                            8'hF7, 8'h07, 8'h00, 8'h7F};
    logic [3:0] ops [9] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR,
                            OP_SLL, OP_SRL, OP_SRA, OP_SLT};
    logic [7:0] exp [9] = '{8'h0C, 8'h3F, 8'h80, 8'hF0, 8'h00,
                            8'h80, 8'h01, 8'h80, 8'h01};
    logic       ez  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(a[i], b[i], ops[i], i == 4);
      tests++;
      if ({zero_flag, alu_result} !== {ez[i], exp[i]}) begin
        fails++;
        $display("FAIL b2b cycle %0d: got %h/%b want %h/%b",
                 i, alu_result, zero_flag, exp[i], ez[i]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in1 = '0;
    in2 = '0;
    alu_ctrl = '0;
    test_reset();
    test_logic_arith();
    test_shift();
    test_compare();
    test_wrap_reserved();
    test_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
